core_mem_router: RTL and testbench

- Parametrised data-side memory router for a core. Sits between the pipeline data port, the core's local dual-port memory (data port B) and the shared bus.
- Replaces the inline address-decode/stall logic of the single-width core with configurable widths and a local-region boundary.
- Adds a posted write buffer so stores to shared memory do not stall the pipeline.
- Enforces ordering so shared reads never bypass buffered shared writes.

---
 rtl/core_mem_router.sv | 169 ++++++++++++++++
 tb/tb_core_mem_router.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_router.sv
// core_mem_router
//   Data-side memory router for a core. Routes pipeline loads and stores either
//   to the core's local dual-port memory (port B) or to the shared bus. Stores to
//   shared memory are posted into a small circular write buffer so the pipeline
//   does not wait for the bus. A shared load waits until the buffer has drained,
//   so it never overtakes an earlier shared store.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   daddr             pipeline data address (word address)
//   ddata_out         pipeline store data
//   dwrite_en         pipeline store request
//   dread_en          pipeline load request
//   ddata_in          load data, valid the cycle after the load is accepted
//   stall             pipeline must hold address, data and enables
//   lmem_addr         local memory port B address
//   lmem_we           local memory write enable
//   lmem_wdata        local memory write data
//   lmem_q            local memory read data (1-cycle latency)
//   shared_request    shared bus request (level)
//   shared_wren       shared bus write strobe
//   shared_rden       shared bus read strobe
//   shared_addr       shared bus address
//   shared_write_val  shared bus write data
//   shared_ready      shared bus completes the current request this cycle
//   shared_read_val   shared bus read data, valid with shared_ready && shared_rden
//   wbuf_level        number of occupied write-buffer entries
module core_mem_router #(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 16,
    parameter int LOCAL_MEMORY_SIZE = 2048,
    parameter int LOCAL_SEL_BITS    = 2,
    parameter int WBUF_DEPTH        = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ADDR_WIDTH-1:0]                daddr,
    input  logic [DATA_WIDTH-1:0]                ddata_out,
    input  logic                                 dwrite_en,
    input  logic                                 dread_en,
    output logic [DATA_WIDTH-1:0]                ddata_in,
    output logic                                 stall,
    output logic [$clog2(LOCAL_MEMORY_SIZE)-1:0] lmem_addr,
    output logic                                 lmem_we,
    output logic [DATA_WIDTH-1:0]                lmem_wdata,
    input  logic [DATA_WIDTH-1:0]                lmem_q,
    output logic                                 shared_request,
    output logic                                 shared_wren,
    output logic                                 shared_rden,
    output logic [ADDR_WIDTH-1:0]                shared_addr,
    output logic [DATA_WIDTH-1:0]                shared_write_val,
    input  logic                                 shared_ready,
    input  logic [DATA_WIDTH-1:0]                shared_read_val,
    output logic [$clog2(WBUF_DEPTH):0]          wbuf_level
);

    localparam int LMEM_AW = $clog2(LOCAL_MEMORY_SIZE);
    localparam int PTR_W   = $clog2(WBUF_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_LOCAL  = 2'd1,
        SEL_SHARED = 2'd2
    } sel_t;

    // Posted write buffer storage (no reset: contents are only meaningful
    // between the pointers)
    logic [ADDR_WIDTH-1:0] wb_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    sel_t                  sel_l;
    logic [DATA_WIDTH-1:0] rd_reg;

    logic is_local;
    logic wb_empty;
    logic wb_full;
    logic push;
    logic pop;
    logic load_accept;

    // Local region: the top LOCAL_SEL_BITS address bits are all zero.
    assign is_local = (daddr[ADDR_WIDTH-1 -: LOCAL_SEL_BITS] == '0);
    assign wb_empty = (count == '0);
    assign wb_full  = (count == CNT_W'(WBUF_DEPTH));

    // Local memory port B is a pure decode of the pipeline request.
    assign lmem_addr  = daddr[LMEM_AW-1:0];
    assign lmem_we    = is_local && dwrite_en;
    assign lmem_wdata = ddata_out;

    // Shared bus: buffered writes always win over a pending shared read, which
    // is what keeps reads from bypassing earlier stores. Both sources are
    // stable while waiting for shared_ready: the head entry only moves on a
    // pop, and the read address is held by the stalled pipeline.
    always_comb begin
        shared_request   = 1'b0;
        shared_wren      = 1'b0;
        shared_rden      = 1'b0;
        shared_addr      = daddr;
        shared_write_val = wb_data[rd_ptr];
        if (!wb_empty) begin
            shared_request = 1'b1;
            shared_wren    = 1'b1;
            shared_addr    = wb_addr[rd_ptr];
        end else if (!is_local && dread_en) begin
            shared_request = 1'b1;
            shared_rden    = 1'b1;
        end
    end

    assign pop = shared_ready && shared_wren;

    // A full buffer still accepts a store in the cycle its head drains.
    // A shared load is only accepted once nothing is buffered and the bus
    // completes the read in the same cycle.
    assign stall = (!is_local && dwrite_en && wb_full && !pop)
                 | (!is_local && dread_en && !(wb_empty && shared_ready));

    assign push        = !is_local && dwrite_en && !stall;
    assign load_accept = dread_en && !stall;

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr] <= daddr;
            wb_data[wr_ptr] <= ddata_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sel_l  <= SEL_NONE;
            rd_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Load return stage: remember where the accepted load went so the
            // next cycle can pick the matching data source.
            if (shared_ready && shared_rden) begin
                rd_reg <= shared_read_val;
            end
            if (load_accept) begin
                sel_l <= is_local ? SEL_LOCAL : SEL_SHARED;
            end else begin
                sel_l <= SEL_NONE;
            end
        end
    end

    assign ddata_in   = (sel_l == SEL_LOCAL) ? lmem_q : rd_reg;
    assign wbuf_level = count;

endmodule

// File: tb/tb_core_mem_router.sv
module tb_core_mem_router;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic        reset;
    logic [15:0] daddr;
    logic [15:0] ddata_out;
    logic        dwrite_en;
    logic        dread_en;
    logic [15:0] ddata_in;
    logic        stall;
    logic [10:0] lmem_addr;
    logic        lmem_we;
    logic [15:0] lmem_wdata;
    logic [15:0] lmem_q;
    logic        shared_request;
    logic        shared_wren;
    logic        shared_rden;
    logic [15:0] shared_addr;
    logic [15:0] shared_write_val;
    logic        shared_ready = 1'b0;
    logic [15:0] shared_read_val;
    logic [2:0]  wbuf_level;

    core_mem_router dut (
        .clk(clk), .reset(reset), .daddr(daddr), .ddata_out(ddata_out),
        .dwrite_en(dwrite_en), .dread_en(dread_en), .ddata_in(ddata_in), .stall(stall),
        .lmem_addr(lmem_addr), .lmem_we(lmem_we), .lmem_wdata(lmem_wdata), .lmem_q(lmem_q),
        .shared_request(shared_request), .shared_wren(shared_wren), .shared_rden(shared_rden),
        .shared_addr(shared_addr), .shared_write_val(shared_write_val),
        .shared_ready(shared_ready), .shared_read_val(shared_read_val), .wbuf_level(wbuf_level)
    );

    // Second instance for the parameter sweep
    logic [15:0] daddr2;
    logic [31:0] ddata_out2;
    logic        dwrite_en2;
    logic        dread_en2;
    logic [31:0] ddata_in2;
    logic        stall2;
    logic [10:0] lmem_addr2;
    logic        lmem_we2;
    logic [31:0] lmem_wdata2;
    logic [31:0] lmem_q2;
    logic        shared_request2;
    logic        shared_wren2;
    logic        shared_rden2;
    logic [15:0] shared_addr2;
    logic [31:0] shared_write_val2;
    logic        shared_ready2;
    logic [31:0] shared_read_val2;
    logic [3:0]  wbuf_level2;

    core_mem_router #(.DATA_WIDTH(32), .WBUF_DEPTH(8), .LOCAL_SEL_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .daddr(daddr2), .ddata_out(ddata_out2),
        .dwrite_en(dwrite_en2), .dread_en(dread_en2), .ddata_in(ddata_in2), .stall(stall2),
        .lmem_addr(lmem_addr2), .lmem_we(lmem_we2), .lmem_wdata(lmem_wdata2), .lmem_q(lmem_q2),
        .shared_request(shared_request2), .shared_wren(shared_wren2), .shared_rden(shared_rden2),
        .shared_addr(shared_addr2), .shared_write_val(shared_write_val2),
        .shared_ready(shared_ready2), .shared_read_val(shared_read_val2), .wbuf_level(wbuf_level2)
    );

    // Environment memories (what the real local RAM and shared bus hold)
    logic [15:0] lmem_slv [16] = '{default: 16'h0000};
    logic [15:0] smem_slv [16] = '{default: 16'h0000};
    // Reference model: program-order view of memory contents
    logic [15:0] lmodel [16] = '{default: 16'h0000};
    logic [15:0] smodel [16] = '{default: 16'h0000};

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    typedef struct {
        int          due;
        logic [15:0] d;
    } ld_t;

    wr_t         wq[$];   // shared stores accepted, not yet seen on the bus
    ld_t         ldq[$];  // loads accepted, data expected at cycle 'due'
    logic [15:0] rdq[$];  // addresses of shared loads issued

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lvl_snap = 0;
    int ready_mode = 0;   // 0: shared_ready follows ready_force, 1: random
    logic ready_force = 1'b0;

    function automatic bit is_loc(input logic [15:0] a);
        return a[15:14] == 2'b00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Local RAM: 1-cycle read latency, aliased on the low 4 address bits
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lmem_we) lmem_slv[lmem_addr[3:0]] <= lmem_wdata;
        lmem_q <= lmem_slv[lmem_addr[3:0]];
    end

    assign shared_read_val = smem_slv[shared_addr[3:0]];

    always @(posedge clk) begin
        if (ready_mode == 1) shared_ready <= ($urandom_range(0, 99) < 45);
        else                 shared_ready <= ready_force;
    end

    // Occupancy seen by the bench must match the DUT every cycle
    always @(posedge clk) begin
        #2;
        chk("wbuf_level", wbuf_level, wq.size());
        lvl_snap = wq.size();
    end

    // Monitor: bus strobes, bus transactions and returned load data
    always @(negedge clk) begin
        bit  exp_w;
        bit  exp_r;
        wr_t e;
        ld_t l;
        exp_w = (lvl_snap > 0);
        exp_r = !exp_w && dread_en && !is_loc(daddr);
        chk("shared_wren", shared_wren, exp_w);
        chk("shared_rden", shared_rden, exp_r);
        chk("shared_request", shared_request, exp_w || exp_r);
        if (shared_request && shared_wren && shared_ready) begin
            if (wq.size() == 0) begin
                fail("bus_write", "write with no buffered store");
            end else begin
                e = wq.pop_front();
                chk("wr_addr", shared_addr, e.a);
                chk("wr_data", shared_write_val, e.d);
                smodel[e.a[3:0]] = e.d;
            end
            smem_slv[shared_addr[3:0]] = shared_write_val;
        end
        if (shared_request && shared_rden && shared_ready) begin
            chk("rd_order_pending_writes", wq.size(), 0);
            if (rdq.size() == 0) fail("bus_read", "read with no load issued");
            else chk("rd_addr", shared_addr, rdq.pop_front());
        end
        if (ldq.size() > 0 && ldq[0].due == cyc) begin
            l = ldq.pop_front();
            chk("load_data", ddata_in, l.d);
        end
    end

    function automatic bit exp_stall(input bit wr, input bit rd, input logic [15:0] a);
        if (is_loc(a)) return 1'b0;
        if (wr) return (lvl_snap == DEPTH) && !(shared_ready && lvl_snap > 0);
        if (rd) return !(lvl_snap == 0 && shared_ready);
        return 1'b0;
    endfunction

    task automatic accept_op(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d);
        if (wr) begin
            chk("lmem_we", lmem_we, is_loc(a));
            if (is_loc(a)) begin
                lmodel[a[3:0]] = d;
            end else begin
                wr_t e;
                e.a = a;
                e.d = d;
                wq.push_back(e);
            end
        end
        if (rd) begin
            ld_t l;
            l.due = cyc + 1;
            l.d   = is_loc(a) ? lmodel[a[3:0]] : smodel[a[3:0]];
            ldq.push_back(l);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the op was accepted
    task automatic do_op(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d);
        bit done;
        daddr     = a;
        ddata_out = d;
        dwrite_en = wr;
        dread_en  = rd;
        if (rd && !is_loc(a)) rdq.push_back(a);
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            chk("stall", stall, exp_stall(wr, rd, a));
            if (!stall) begin
                accept_op(wr, rd, a, d);
                done = 1'b1;
            end
        end
        if (!done) fail("op_timeout", "operation never accepted");
        @(posedge clk); #1;
        dwrite_en = 1'b0;
        dread_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            if (wq.size() == 0 && rdq.size() == 0 && ldq.size() == 0) done = 1'b1;
        end
        if (!done) fail("drain_timeout", "write buffer never drained");
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        wq.delete();
        rdq.delete();
        ldq.delete();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  idx;
        int          r;

        reset = 1'b1;
        daddr = '0; ddata_out = '0; dwrite_en = 1'b0; dread_en = 1'b0;
        daddr2 = '0; ddata_out2 = '0; dwrite_en2 = 1'b0; dread_en2 = 1'b0;
        shared_ready2 = 1'b0; lmem_q2 = '0; shared_read_val2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_request", shared_request, 1'b0);
        chk("rst_level", wbuf_level, 0);
        chk("rst_ddata_in", ddata_in, 16'h0000);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk); #1;

        // Local store then load
        do_op(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        do_op(1'b0, 1'b1, 16'h0010, 16'h0000);
        @(negedge clk);
        chk("local_load_beef", ddata_in, 16'hBEEF);
        @(posedge clk); #1;

        // Fill the buffer with the bus stalled, then a fifth store
        ready_force = 1'b0;
        idle(2);
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 16'h8000 + 16'(i), 16'hA000 + 16'(i));
        chk("level_full", wbuf_level, 4);
        daddr = 16'h8004; ddata_out = 16'hA004; dwrite_en = 1'b1;
        ready_force = 1'b1;
        @(negedge clk);
        chk("fifth_store_stall", stall, 1'b1);
        @(posedge clk); #1;
        ready_force = 1'b0;
        @(negedge clk);
        chk("fifth_store_accept", stall, 1'b0);
        if (!stall) accept_op(1'b1, 1'b0, 16'h8004, 16'hA004);
        @(posedge clk); #1;
        dwrite_en = 1'b0;
        chk("level_after_pop_push", wbuf_level, 4);
        ready_force = 1'b1;
        drain();

        // Two shared stores then a shared load of the second
        do_op(1'b1, 1'b0, 16'h8000, 16'hAAAA);
        do_op(1'b1, 1'b0, 16'h8001, 16'h1234);
        do_op(1'b0, 1'b1, 16'h8001, 16'h0000);
        @(negedge clk);
        chk("shared_load_1234", ddata_in, 16'h1234);
        @(posedge clk); #1;

        // Local traffic while a shared store waits on the bus
        ready_force = 1'b0;
        idle(2);
        do_op(1'b1, 1'b0, 16'hC000, 16'h0C0C);
        do_op(1'b1, 1'b0, 16'h0013, 16'h7777);
        do_op(1'b0, 1'b1, 16'h0013, 16'h0000);
        do_op(1'b1, 1'b0, 16'h0214, 16'h4242);
        do_op(1'b0, 1'b1, 16'h0010, 16'h0000);
        chk("drain_hold_level", wbuf_level, 1);
        chk("drain_hold_request", shared_request, 1'b1);
        ready_force = 1'b1;
        drain();

        // Reset with three buffered stores pending
        ready_force = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 16'h8004 + 16'(i), 16'hB000 + 16'(i));
        chk("pre_reset_level", wbuf_level, 3);
        do_reset();
        @(negedge clk);
        chk("post_reset_request", shared_request, 1'b0);
        chk("post_reset_level", wbuf_level, 0);
        chk("post_reset_ddata_in", ddata_in, 16'h0000);
        @(posedge clk); #1;
        ready_force = 1'b1;
        do_op(1'b1, 1'b0, 16'h9000, 16'h5555);
        drain();

        // Randomized mix
        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            r   = $urandom_range(0, 9);
            idx = 4'($urandom_range(0, 15));
            d   = 16'($urandom);
            if (r < 4) a = {2'b00, 10'($urandom), idx};
            else       a = {2'($urandom_range(1, 3)), 10'($urandom), idx};
            case (r)
                0, 1:    do_op(1'b1, 1'b0, a, d);
                2, 3:    do_op(1'b0, 1'b1, a, d);
                4, 5, 6: do_op(1'b1, 1'b0, a, d);
                7, 8:    do_op(1'b0, 1'b1, a, d);
                default: idle(1);
            endcase
        end
        ready_mode  = 0;
        ready_force = 1'b1;
        drain();

        // Parameter sweep instance: 32-bit data, 8 entries, 1 select bit
        for (int i = 0; i < 8; i++) begin
            daddr2 = 16'h8000 + 16'(i); ddata_out2 = 32'hDEAD0000 + 32'(i); dwrite_en2 = 1'b1;
            @(negedge clk);
            chk("sweep_store_no_stall", stall2, 1'b0);
            @(posedge clk); #1;
        end
        daddr2 = 16'h8008;
        @(negedge clk);
        chk("sweep_ninth_stall", stall2, 1'b1);
        chk("sweep_level", wbuf_level2, 8);
        @(posedge clk); #1;
        daddr2 = 16'h7FFF;
        @(negedge clk);
        chk("sweep_7fff_local_we", lmem_we2, 1'b1);
        chk("sweep_7fff_no_stall", stall2, 1'b0);
        @(posedge clk); #1;
        daddr2 = 16'h8000;
        @(negedge clk);
        chk("sweep_8000_not_local", lmem_we2, 1'b0);
        chk("sweep_8000_stall", stall2, 1'b1);
        @(posedge clk); #1;
        dwrite_en2 = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
